// File: rtl/pad_dram_ctrl.sv
// Pad-side bridge that turns command/data words from the chip into DRAM word
// writes, or into paced DRAM reads returned through a 2-entry skid FIFO.
module pad_dram_ctrl #(
  parameter int PORT_WIDTH      = 128,
  parameter int SRAM_WIDTH      = 256,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ITFPAD_DatOE,
  input  logic [PORT_WIDTH-1:0]      ITFPAD_Dat,
  input  logic                       ITFPAD_DatVld,
  input  logic                       ITFPAD_DatLast,
  output logic                       PADITF_DatRdy,
  output logic [PORT_WIDTH-1:0]      PADITF_Dat,
  output logic                       PADITF_DatVld,
  output logic                       PADITF_DatLast,
  input  logic                       ITFPAD_DatRdy,
  output logic [DRAM_ADDR_WIDTH-1:0] MemAddr,
  output logic                       MemWr,
  output logic [PORT_WIDTH-1:0]      MemWrDat,
  output logic                       MemRd,
  input  logic [PORT_WIDTH-1:0]      MemRdDat,
  output logic                       Busy,
  output logic                       Err
);

  localparam int RATIO = SRAM_WIDTH / PORT_WIDTH;
  localparam int LOG2R = $clog2(RATIO);
  localparam int BW    = ADDR_WIDTH + LOG2R;

  typedef enum logic [1:0] {IDLE, WR, RD, FNH} state_t;

  state_t                     state, state_nxt;
  logic [DRAM_ADDR_WIDTH-1:0] base;
  logic [BW-1:0]              beats;
  logic [BW-1:0]              cnt;
  logic [BW-1:0]              pop_cnt;
  logic                       inflight;
  logic [PORT_WIDTH-1:0]      fifo_mem [2];
  logic                       wr_ptr, rd_ptr;
  logic [1:0]                 fifo_cnt;
  logic                       err_q, err_set;

  logic                       cmd_dir;
  logic [DRAM_ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0]      cmd_req;
  logic                       accept, pop, cnt_last, pop_last;
  logic [1:0]                 occ_net;

  assign cmd_dir  = ITFPAD_Dat[0];
  assign cmd_addr = ITFPAD_Dat[DRAM_ADDR_WIDTH:1];
  assign cmd_req  = ITFPAD_Dat[DRAM_ADDR_WIDTH+ADDR_WIDTH:DRAM_ADDR_WIDTH+1];

  assign accept   = (state == IDLE) && ITFPAD_DatVld && ITFPAD_DatOE;
  assign pop      = (fifo_cnt != 2'd0) && ITFPAD_DatRdy;
  assign cnt_last = (cnt == beats - BW'(1));
  assign pop_last = (pop_cnt == beats - BW'(1));
  // A same-cycle pop frees a slot, which is what allows one beat per cycle.
  assign occ_net  = fifo_cnt + {1'b0, inflight} - {1'b0, pop};

  assign PADITF_DatVld  = (fifo_cnt != 2'd0);
  assign PADITF_Dat     = PADITF_DatVld ? fifo_mem[rd_ptr] : '0;
  assign PADITF_DatLast = PADITF_DatVld && pop_last;
  assign MemWrDat       = ITFPAD_Dat;
  assign Busy           = (state != IDLE);
  assign Err            = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    PADITF_DatRdy = 1'b0;
    MemWr         = 1'b0;
    MemRd         = 1'b0;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        PADITF_DatRdy = 1'b1;
        if (accept) begin
          err_set = (cmd_req == '0) || !ITFPAD_DatLast;
          if (cmd_req == '0) state_nxt = FNH;
          else if (cmd_dir)  state_nxt = WR;
          else               state_nxt = RD;
        end
      end
      WR: begin
        PADITF_DatRdy = 1'b1;
        if (ITFPAD_DatVld) begin
          MemWr   = 1'b1;
          err_set = (ITFPAD_DatLast != cnt_last);
          if (cnt_last) state_nxt = FNH;
        end
      end
      RD: begin
        MemRd = (cnt < beats) && (occ_net < 2'd2);
        if (pop && pop_last) state_nxt = FNH;
      end
      FNH:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    MemAddr = (MemWr || MemRd) ? base + DRAM_ADDR_WIDTH'(cnt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base        <= '0;
      beats       <= '0;
      cnt         <= '0;
      pop_cnt     <= '0;
      inflight    <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      err_q    <= err_set;
      inflight <= MemRd;
      if (accept) begin
        base    <= cmd_addr << LOG2R;
        beats   <= BW'(cmd_req) << LOG2R;
        cnt     <= '0;
        pop_cnt <= '0;
      end else begin
        if (MemWr || MemRd) cnt <= cnt + BW'(1);
        if (pop)            pop_cnt <= pop_cnt + BW'(1);
      end
      // Read data lands exactly one cycle after its strobe.
      if (inflight) begin
        fifo_mem[wr_ptr] <= MemRdDat;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_pad_dram_ctrl.sv
// Directed, table-driven bench for pad_dram_ctrl with a one-cycle-latency memory model.
module tb_pad_dram_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ITFPAD_DatOE = 1'b0;
  logic [127:0] ITFPAD_Dat = '0;
  logic         ITFPAD_DatVld = 1'b0;
  logic         ITFPAD_DatLast = 1'b0;
  logic         PADITF_DatRdy;
  logic [127:0] PADITF_Dat;
  logic         PADITF_DatVld;
  logic         PADITF_DatLast;
  logic         ITFPAD_DatRdy = 1'b0;
  logic [31:0]  MemAddr;
  logic         MemWr;
  logic [127:0] MemWrDat;
  logic         MemRd;
  logic [127:0] MemRdDat = '0;
  logic         Busy;
  logic         Err;

  int checks = 0;
  int errors = 0;

  pad_dram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ITFPAD_DatOE(ITFPAD_DatOE), .ITFPAD_Dat(ITFPAD_Dat),
    .ITFPAD_DatVld(ITFPAD_DatVld), .ITFPAD_DatLast(ITFPAD_DatLast),
    .PADITF_DatRdy(PADITF_DatRdy), .PADITF_Dat(PADITF_Dat),
    .PADITF_DatVld(PADITF_DatVld), .PADITF_DatLast(PADITF_DatLast),
    .ITFPAD_DatRdy(ITFPAD_DatRdy), .MemAddr(MemAddr), .MemWr(MemWr),
    .MemWrDat(MemWrDat), .MemRd(MemRd), .MemRdDat(MemRdDat),
    .Busy(Busy), .Err(Err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  // Memory returns data the cycle after the strobe and otherwise holds it.
  always @(posedge clk) if (MemRd) MemRdDat <= pat(MemAddr);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkcmd(input logic dir, input logic [31:0] a, input logic [15:0] n);
    logic [127:0] c;
    c = '0;
    c[0] = dir;
    c[32:1] = a;
    c[48:33] = n;
    return c;
  endfunction

  function automatic logic [127:0] dw(input int k);
    return {96'hFEED_FACE_0123_4567_89AB_CDEF, 32'(k)};
  endfunction

  typedef struct {
    logic         oe, vld, last;
    logic [127:0] dat;
    logic         e_rdy, e_wr;
    logic [31:0]  e_addr;
    logic         e_busy, e_err;
  } vec_t;

  function automatic vec_t mk(input logic oe, vld, last, input logic [127:0] dat,
                              input logic e_rdy, e_wr, input logic [31:0] e_addr,
                              input logic e_busy, e_err);
    vec_t v;
    v.oe = oe; v.vld = vld; v.last = last; v.dat = dat;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_busy", Busy, 0);
    chk("rst_err", Err, 0);
    chk("rst_memwr", MemWr, 0);
    chk("rst_memrd", MemRd, 0);
    chk("rst_vld", PADITF_DatVld, 0);
    chk("rst_last", PADITF_DatLast, 0);
    chk("rst_dat", PADITF_Dat, 0);
    chk("rst_addr", MemAddr, 0);
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_read(input logic [31:0] a, input logic [15:0] n, input bit toggle, input int stop_after);
    int          beats;
    logic [31:0] base;
    int          issued, popped, cyc, first_vld;
    bit          done;
    beats = 2 * int'(n);
    base = a * 2;
    issued = 0; popped = 0; cyc = 0; first_vld = -1; done = 0;
    ITFPAD_DatOE = 1; ITFPAD_DatVld = 1; ITFPAD_DatLast = 1;
    ITFPAD_Dat = mkcmd(1'b0, a, n); ITFPAD_DatRdy = 0;
    @(negedge clk);
    chk("rd_cmd_rdy", PADITF_DatRdy, 1);
    @(posedge clk); #1;
    ITFPAD_DatOE = 0; ITFPAD_DatLast = 0; ITFPAD_Dat = '0;
    ITFPAD_DatVld = 1;  // stray valid during a read must not be acknowledged
    while (!done && cyc < 100) begin
      ITFPAD_DatRdy = toggle ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      chk("rd_outstanding", (issued - popped) <= 2, 1);
      chk("rd_no_wr", MemWr, 0);
      chk("rd_rdy_low", PADITF_DatRdy, 0);
      if (MemRd) begin
        chk("rd_addr", MemAddr, base + 32'(issued));
        if (!toggle) chk("rd_issue_cycle", cyc, issued);
        issued++;
      end
      if (PADITF_DatVld) begin
        if (first_vld < 0) begin
          first_vld = cyc;
          chk("rd_first_vld_cycle", cyc, 2);
        end
        chk("rd_last", PADITF_DatLast, popped == beats - 1);
        if (ITFPAD_DatRdy) begin
          chk("rd_data", PADITF_Dat, pat(base + 32'(popped)));
          popped++;
          if (popped == beats) done = 1;
          if (stop_after >= 0 && popped == stop_after) done = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    ITFPAD_DatVld = 0;
    ITFPAD_DatRdy = 0;
    if (!done) chk("rd_timeout", 0, 1);
    if (stop_after < 0) begin
      chk("rd_beats", popped, beats);
      chk("rd_issued", issued, beats);
      @(negedge clk);
      chk("rd_fnh_busy", Busy, 1);
      chk("rd_fnh_vld", PADITF_DatVld, 0);
      chk("rd_fnh_memrd", MemRd, 0);
      chk("rd_fnh_rdy", PADITF_DatRdy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rd_idle_busy", Busy, 0);
      chk("rd_idle_rdy", PADITF_DatRdy, 1);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl [21];

  initial begin
    tbl[0]  = mk(1, 1, 1, mkcmd(1, 32'h10, 16'd2), 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      tbl[1+k] = mk(1, 1, k == 3, dw(k), 1, 1, 32'h20 + 32'(k), 1, 0);
    tbl[5]  = mk(0, 0, 0, '0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, '0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, mkcmd(1, 32'h4, 16'd2), 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, dw(10), 1, 1, 32'h8, 1, 0);
    tbl[9]  = mk(1, 1, 1, dw(11), 1, 1, 32'h9, 1, 0);
    tbl[10] = mk(1, 1, 0, dw(12), 1, 1, 32'hA, 1, 1);
    tbl[11] = mk(1, 1, 1, dw(13), 1, 1, 32'hB, 1, 0);
    tbl[12] = mk(0, 0, 0, '0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 1, 1, mkcmd(1, 32'h5, 16'd0), 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 1, dw(99), 0, 0, 0, 1, 1);
    tbl[15] = mk(0, 0, 0, '0, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 0, mkcmd(1, 32'h3, 16'd1), 1, 0, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, dw(20), 1, 1, 32'h6, 1, 1);
    tbl[18] = mk(1, 1, 1, dw(21), 1, 1, 32'h7, 1, 0);
    tbl[19] = mk(0, 0, 0, '0, 0, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, 0, '0, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("idle_rdy", PADITF_DatRdy, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      ITFPAD_DatOE = tbl[i].oe;
      ITFPAD_DatVld = tbl[i].vld;
      ITFPAD_DatLast = tbl[i].last;
      ITFPAD_Dat = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), PADITF_DatRdy, tbl[i].e_rdy);
      chk($sformatf("v%0d_memwr", i), MemWr, tbl[i].e_wr);
      chk($sformatf("v%0d_memrd", i), MemRd, 0);
      chk($sformatf("v%0d_addr", i), MemAddr, tbl[i].e_addr);
      chk($sformatf("v%0d_busy", i), Busy, tbl[i].e_busy);
      chk($sformatf("v%0d_err", i), Err, tbl[i].e_err);
      if (tbl[i].e_wr) chk($sformatf("v%0d_wrdat", i), MemWrDat, tbl[i].dat);
      @(posedge clk); #1;
    end
    ITFPAD_DatOE = 0; ITFPAD_DatVld = 0; ITFPAD_DatLast = 0; ITFPAD_Dat = '0;

    run_read(32'h8, 16'd3, 1'b0, -1);
    run_read(32'h8, 16'd3, 1'b1, -1);
    run_read(32'h40, 16'd3, 1'b0, 2);

    rst_n = 0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_vld", PADITF_DatVld, 0);
    chk("post_rst_rdy", PADITF_DatRdy, 1);
    @(posedge clk); #1;
    run_read(32'h20, 16'd2, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_dram_ctrl.md
PAD_DRAM_CTRL -- requirements
Module: pad_dram_ctrl

Interface
REQ-001 SHALL have parameters: PORT_WIDTH, 128, pad word width; SRAM_WIDTH, 256, on-chip word width; DRAM_ADDR_WIDTH, 32, memory address width; ADDR_WIDTH, 16, request-count width.
REQ-002 SHALL have ports, with reset rst_n asynchronous, active-low, and clock clk:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ITFPAD_DatOE  in  1  chip driving pad
- ITFPAD_Dat  in  PORT_WIDTH  command or data from chip
- ITFPAD_DatVld  in  1  chip word valid
- ITFPAD_DatLast  in  1  chip word last
- PADITF_DatRdy  out  1  ready to chip
- PADITF_Dat  out  PORT_WIDTH  read data to chip
- PADITF_DatVld  out  1  read data valid
- PADITF_DatLast  out  1  final read beat
- ITFPAD_DatRdy  in  1  chip ready for read data
- MemAddr  out  DRAM_ADDR_WIDTH  memory word address, PORT_WIDTH units
- MemWr  out  1  write strobe
- MemWrDat  out  PORT_WIDTH  write data
- MemRd  out  1  read strobe
- MemRdDat  in  PORT_WIDTH  read data, valid exactly 1 cycle after MemRd
- Busy  out  1  state != IDLE
- Err  out  1  one-cycle protocol-error pulse

Function
REQ-003 SHALL define RATIO = SRAM_WIDTH/PORT_WIDTH (integer power of two, >=1).
REQ-004 SHALL decode a command word: bit0 Dir (1 = chip sends data, memory write; 0 = chip receives data, memory read); bits [DRAM_ADDR_WIDTH:1] Addr, in SRAM_WIDTH words; bits [DRAM_ADDR_WIDTH+ADDR_WIDTH:DRAM_ADDR_WIDTH+1] ReqNum, in SRAM_WIDTH words.
REQ-005 SHALL implement states IDLE, WR, RD, FNH.
REQ-006 IDLE: PADITF_DatRdy=1; a command is accepted on ITFPAD_DatVld & ITFPAD_DatOE & PADITF_DatRdy. It latches Base = Addr*RATIO (truncated to DRAM_ADDR_WIDTH) and Beats = ReqNum*RATIO (width ADDR_WIDTH+log2(RATIO)), clears the beat counter, and moves to WR (Dir=1) or RD (Dir=0).
REQ-007 SHALL, when the accepted command has ReqNum=0, pulse Err and go to FNH with no memory access.
REQ-008 SHALL, when the accepted command has ITFPAD_DatLast=0, pulse Err but still execute the command.
REQ-009 WR: PADITF_DatRdy=1; each handshake ITFPAD_DatVld&PADITF_DatRdy drives MemWr=1, MemAddr=Base+cnt, MemWrDat=ITFPAD_Dat in the same cycle (combinational), then cnt+1.
REQ-010 WR: the beat with cnt=Beats-1 completes the transfer -> FNH. ITFPAD_DatLast mismatch (Last on any other beat, or absent on the final beat) SHALL pulse Err; a transfer SHALL end only on the count, never on Last.
REQ-011 RD: PADITF_DatRdy=0; MemRd SHALL be issued with MemAddr=Base+issue_cnt only while issue_cnt<Beats and (fifo_count + inflight) < 2.
REQ-012 SHALL hold a 2-entry FIFO that captures MemRdDat the cycle after each MemRd; PADITF_Dat/Vld present the FIFO head; a pop occurs on PADITF_DatVld&ITFPAD_DatRdy. Full plus inflight SHALL never overflow.
REQ-013 SHALL assert PADITF_DatLast with the head beat whose return index = Beats-1; that beat's pop -> FNH.
REQ-014 With ITFPAD_DatRdy held 1, SHALL sustain 1 beat/cycle; first PADITF_DatVld 2 cycles after RD entry.
REQ-015 FNH: single cycle, all strobes 0, -> IDLE.
REQ-016 MemWr and MemRd SHALL never assert simultaneously; MemAddr=0 when neither asserted.
REQ-017 ITFPAD_DatVld in RD or FNH SHALL be ignored (not acknowledged).

Reset
REQ-018 On rst_n low: state=IDLE, counters=0, FIFO empty, Busy=0, Err=0, MemWr=MemRd=0, PADITF_DatVld=PADITF_DatLast=0, PADITF_Dat=0, MemAddr=0; PADITF_DatRdy=1 after release.
REQ-019 Reset mid-transfer SHALL discard FIFO contents and inflight reads; a MemRdDat arriving after release SHALL be dropped.

Verification
REQ-020 Write: cmd Dir=1, Addr=0x10, ReqNum=2, then 4 beats D0..D3 (Last on D3) -> MemWr at addresses 0x20..0x23 with D0..D3, FNH, IDLE, Err=0.
REQ-021 Read with ITFPAD_DatRdy=1: cmd Dir=0, Addr=0x8, ReqNum=3 -> MemRd 0x10..0x15 on consecutive cycles, 6 PADITF beats, Last on the 6th only.
REQ-022 Read backpressure: same as REQ-021 with ITFPAD_DatRdy toggling 1,0,0,1... -> no beat lost or duplicated; MemRd stalls when FIFO+inflight=2; data order preserved.
REQ-023 ReqNum=0 command -> Err pulse 1 cycle, no MemWr/MemRd, IDLE after FNH.
REQ-024 Write with early Last on beat 1 of 4 -> Err pulse; all 4 beats written; FNH after beat 3.
REQ-025 Reset asserted during read after 2 beats -> all outputs at reset values; the next read command completes correctly.
